uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_parser.sv | 95 +++++++++
 tb/tb_uart_frame_parser.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// Byte-stream framer behind uart_rx: hunts SOF/LEN/payload/checksum frames,
// buffers the payload and releases it downstream only after the checksum matches.
module uart_frame_parser #(
  parameter int         MAX_LEN = 16,
  parameter logic [7:0] SOF     = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       len_err
);
  localparam int LW = $clog2(MAX_LEN + 1);

  typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, EMIT} state_t;

  state_t        state, state_nxt;
  logic [LW-1:0] len, wr_idx, rd_idx;
  logic [7:0]    sum;
  // Sized to the full index range so every index value is in bounds.
  logic [7:0]    buf_mem [2**LW];
  logic          acc, len_bad, wr_last, rd_last, emit_hs;

  assign acc     = in_valid && in_ready;
  assign len_bad = (in_data == 8'd0) || (in_data > 8'(MAX_LEN));
  assign wr_last = (wr_idx == len - LW'(1));
  assign rd_last = (rd_idx == len - LW'(1));
  assign emit_hs = (state == EMIT) && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT:    if (acc && in_data == SOF) state_nxt = LEN;
      LEN:     if (acc) state_nxt = len_bad ? HUNT : PAYLOAD;
      PAYLOAD: if (acc && wr_last) state_nxt = CHECK;
      CHECK:   if (acc) state_nxt = (in_data == sum) ? EMIT : HUNT;
      EMIT:    if (emit_hs && rd_last) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    in_ready  = (state != EMIT);
    out_valid = (state == EMIT);
    out_data  = (state == EMIT) ? buf_mem[rd_idx] : 8'd0;
    out_last  = (state == EMIT) && rd_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len      <= '0;
      wr_idx   <= '0;
      rd_idx   <= '0;
      sum      <= '0;
      frame_ok <= 1'b0;
      crc_err  <= 1'b0;
      len_err  <= 1'b0;
    end else begin
      frame_ok <= (state == CHECK) && acc && (in_data == sum);
      crc_err  <= (state == CHECK) && acc && (in_data != sum);
      len_err  <= (state == LEN) && acc && len_bad;
      case (state)
        LEN: if (acc && !len_bad) begin
          len    <= in_data[LW-1:0];
          sum    <= in_data;
          wr_idx <= '0;
        end
        PAYLOAD: if (acc) begin
          sum    <= sum + in_data;
          wr_idx <= wr_idx + LW'(1);
        end
        CHECK: if (acc) rd_idx <= '0;
        EMIT:  if (out_ready) rd_idx <= rd_idx + LW'(1);
        default: ;
      endcase
    end
  end

  // Payload storage carries no reset; contents are only read after a full write.
  always_ff @(posedge clk) begin
    if (state == PAYLOAD && acc) buf_mem[wr_idx] <= in_data;
  end
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: inputs change 2ns after posedge,
// a negedge monitor records output handshakes, pulses and protocol violations.
module tb_uart_frame_parser;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, out_last, frame_ok, crc_err, len_err;
  logic [7:0] out_data;

  uart_frame_parser #(.MAX_LEN(16), .SOF(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .frame_ok(frame_ok), .crc_err(crc_err), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0, chk_cnt = 0;
  logic [8:0] out_q[$];
  int n_ok, n_crc, n_len, stall_err, overlap_err, multi_err, wide_err, first_miss, stall_seen;
  logic prev_valid, prev_stall, prev_pulse;
  logic [8:0] prev_word;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0; prev_stall = 1'b0; prev_pulse = 1'b0;
    end else begin
      if (prev_stall && (!out_valid || {out_last, out_data} !== prev_word)) stall_err++;
      if (out_valid && !prev_valid && !frame_ok) first_miss++;
      if (frame_ok && !(out_valid && !prev_valid)) first_miss++;
      if (out_valid && in_ready) overlap_err++;
      if ((frame_ok && crc_err) || (frame_ok && len_err) || (crc_err && len_err)) multi_err++;
      if (prev_pulse && (frame_ok || crc_err || len_err)) wide_err++;
      if (frame_ok) n_ok++;
      if (crc_err) n_crc++;
      if (len_err) n_len++;
      if (out_valid && out_ready) out_q.push_back({out_last, out_data});
      if (out_valid && !out_ready) stall_seen++;
      prev_valid = out_valid;
      prev_stall = out_valid && !out_ready;
      prev_word  = {out_last, out_data};
      prev_pulse = frame_ok || crc_err || len_err;
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic clr();
    out_q.delete();
    n_ok = 0; n_crc = 0; n_len = 0; stall_err = 0; overlap_err = 0;
    multi_err = 0; wide_err = 0; first_miss = 0; stall_seen = 0;
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    in_data = b; in_valid = 1'b1;
    while (!in_ready && n < 300) begin cyc(); n++; end
    if (!in_ready) begin
      chk_cnt++;
      $display("FAIL send_timeout: byte %h saw in_ready=0, required 1", b);
    end
    cyc();
  endtask

  // Sends the n bytes held in the low end of v, most significant first; leaves in_valid high.
  task automatic send_seq(input logic [191:0] v, input int n);
    for (int i = 0; i < n; i++) send(v[8*(n-1-i) +: 8]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc(2);
    chk_cnt++;
    if ({in_ready, out_valid, out_last, out_data} !== {1'b1, 1'b0, 1'b0, 8'h00})
      $display("FAIL reset_outputs: got %b, required 1_0_0_00000000", {in_ready, out_valid, out_last, out_data});
    else pass_cnt++;
    chk_cnt++;
    if ({frame_ok, crc_err, len_err} !== 3'b000)
      $display("FAIL reset_pulses: got %b, required 000", {frame_ok, crc_err, len_err});
    else pass_cnt++;
    rst_n = 1'b1;
    cyc(2);
  endtask

  task automatic test_good_frame();
    clr();
    send_seq({8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69}, 6);
    in_valid = 1'b0;
    cyc(8);
    chk_cnt++;
    if (out_q.size() !== 3) $display("FAIL good_count: got %0d bytes, required 3", out_q.size());
    else pass_cnt++;
    chk_cnt++;
    if ({out_q[0], out_q[1], out_q[2]} !== {9'h011, 9'h022, 9'h133})
      $display("FAIL good_data: got %h %h %h, required 011 022 133", out_q[0], out_q[1], out_q[2]);
    else pass_cnt++;
    chk_cnt++;
    if ({n_ok, n_crc, n_len, first_miss} !== {32'd1, 32'd0, 32'd0, 32'd0})
      $display("FAIL good_pulses: ok=%0d crc=%0d len=%0d first_miss=%0d, required 1 0 0 0", n_ok, n_crc, n_len, first_miss);
    else pass_cnt++;
  endtask

  task automatic test_bad_crc();
    clr();
    send_seq({8'hA5, 8'h02, 8'h10, 8'h20, 8'h00}, 5);
    in_valid = 1'b0;
    cyc(5);
    chk_cnt++;
    if ({out_q.size(), n_crc, n_ok} !== {32'd0, 32'd1, 32'd0})
      $display("FAIL crc_drop: out=%0d crc=%0d ok=%0d, required 0 1 0", out_q.size(), n_crc, n_ok);
    else pass_cnt++;
    send_seq({8'hA5, 8'h01, 8'h7E, 8'h7F}, 4);
    in_valid = 1'b0;
    cyc(5);
    chk_cnt++;
    if (out_q.size() !== 1 || out_q[0] !== 9'h17E)
      $display("FAIL crc_recover: got %0d bytes first %h, required 1 byte 17e", out_q.size(), out_q[0]);
    else pass_cnt++;
    chk_cnt++;
    if ({n_ok, n_crc} !== {32'd1, 32'd1})
      $display("FAIL crc_recover_pulses: ok=%0d crc=%0d, required 1 1", n_ok, n_crc);
    else pass_cnt++;
  endtask

  task automatic test_garbage_sof();
    clr();
    send_seq({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'hA8}, 8);
    in_valid = 1'b0;
    cyc(6);
    chk_cnt++;
    if (out_q.size() !== 2 || {out_q[0], out_q[1]} !== {9'h0A5, 9'h101})
      $display("FAIL sof_payload: got %0d bytes %h %h, required 0a5 101", out_q.size(), out_q[0], out_q[1]);
    else pass_cnt++;
    chk_cnt++;
    if ({n_ok, n_crc, n_len} !== {32'd1, 32'd0, 32'd0})
      $display("FAIL sof_pulses: ok=%0d crc=%0d len=%0d, required 1 0 0", n_ok, n_crc, n_len);
    else pass_cnt++;
  endtask

  task automatic test_len_err();
    clr();
    send_seq({8'hA5, 8'h00}, 2);
    in_valid = 1'b0;
    cyc(2);
    chk_cnt++;
    if ({n_len, 31'd0, in_ready} !== {32'd1, 32'd1})
      $display("FAIL len_zero: len_err=%0d in_ready=%b, required 1 1", n_len, in_ready);
    else pass_cnt++;
    send_seq({8'hA5, 8'h11}, 2);
    in_valid = 1'b0;
    cyc(2);
    chk_cnt++;
    if (n_len !== 2) $display("FAIL len_over: len_err count %0d, required 2", n_len);
    else pass_cnt++;
    send_seq({8'hA5, 8'h01, 8'h7E, 8'h7F}, 4);
    in_valid = 1'b0;
    cyc(5);
    chk_cnt++;
    if (out_q.size() !== 1 || out_q[0] !== 9'h17E || n_ok !== 1)
      $display("FAIL len_recover: got %0d bytes first %h ok=%0d, required 1 byte 17e ok=1", out_q.size(), out_q[0], n_ok);
    else pass_cnt++;
    chk_cnt++;
    if ({multi_err, wide_err, n_crc} !== {32'd0, 32'd0, 32'd0})
      $display("FAIL len_pulse_shape: multi=%0d wide=%0d crc=%0d, required 0 0 0", multi_err, wide_err, n_crc);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int bad = 0;
    clr();
    out_ready = 1'b0;
    fork
      begin
        send_seq({8'hA5, 8'h10, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                  8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h88}, 19);
        send_seq({8'hA5, 8'h01, 8'h42, 8'h43}, 4);
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        while (!out_valid && n < 300) begin cyc(); n++; end
        cyc(2);
        while (out_q.size() < 17 && n < 900) begin
          out_ready = 1'($urandom_range(0, 1));
          cyc();
          n++;
        end
        out_ready = 1'b1;
      end
    join
    cyc(5);
    chk_cnt++;
    if (out_q.size() !== 17) $display("FAIL bp_count: got %0d bytes, required 17", out_q.size());
    else pass_cnt++;
    for (int i = 0; i < 16; i++)
      if (out_q[i] !== {(i == 15), 8'(i)}) bad++;
    chk_cnt++;
    if (bad !== 0) $display("FAIL bp_order: %0d payload bytes wrong, required 0", bad);
    else pass_cnt++;
    chk_cnt++;
    if (out_q[16] !== 9'h142) $display("FAIL bp_next_frame: got %h, required 142", out_q[16]);
    else pass_cnt++;
    chk_cnt++;
    if ({stall_err, overlap_err, n_ok} !== {32'd0, 32'd0, 32'd2})
      $display("FAIL bp_protocol: stall_err=%0d overlap=%0d ok=%0d, required 0 0 2", stall_err, overlap_err, n_ok);
    else pass_cnt++;
    chk_cnt++;
    if (stall_seen < 2) $display("FAIL bp_stalls: saw %0d stalled cycles, required at least 2", stall_seen);
    else pass_cnt++;
    chk_cnt++;
    if (first_miss !== 0) $display("FAIL bp_frame_ok_align: got %0d misaligned, required 0", first_miss);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    clr();
    send_seq({8'hA5, 8'h04, 8'h01, 8'h02}, 4);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid, frame_ok, crc_err, len_err, in_ready} !== 5'b00001)
      $display("FAIL rst_mid_payload: got %b, required 00001", {out_valid, frame_ok, crc_err, len_err, in_ready});
    else pass_cnt++;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    // Second abort: reset while a good frame is stalled in its emit phase.
    out_ready = 1'b0;
    send_seq({8'hA5, 8'h02, 8'h31, 8'h32, 8'h65}, 5);
    in_valid = 1'b0;
    cyc(2);
    chk_cnt++;
    if (out_valid !== 1'b1) $display("FAIL rst_emit_setup: out_valid %b, required 1", out_valid);
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({out_valid, out_last, out_data, in_ready} !== {1'b0, 1'b0, 8'h00, 1'b1})
      $display("FAIL rst_mid_emit: got %b, required 0_0_00000000_1", {out_valid, out_last, out_data, in_ready});
    else pass_cnt++;
    cyc(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc(1);
    send_seq({8'hA5, 8'h01, 8'h55, 8'h56}, 4);
    in_valid = 1'b0;
    cyc(6);
    chk_cnt++;
    if (out_q.size() !== 1 || out_q[0] !== 9'h155)
      $display("FAIL rst_recover: got %0d bytes first %h, required 1 byte 155", out_q.size(), out_q[0]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_garbage_sof();
    test_len_err();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at 500us, required completion");
    $fatal(1);
  end
endmodule
